// File: rtl/bf_pkg.sv
// Shared types for the instruction-execution sequencer.
//   state_t : sequencer FSM states
//   phase_t : timed execution phase owned by a state (PH_NONE for untimed states)
//   phase_of: maps a state to its execution phase
package bf_pkg;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_READ   = 3'd1,
    S_DECODE = 3'd2,
    S_WRITE  = 3'd3,
    S_DBG    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_READ   = 2'd1,
    PH_DECODE = 2'd2,
    PH_WRITE  = 2'd3
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      S_READ:   return PH_READ;
      S_DECODE: return PH_DECODE;
      S_WRITE:  return PH_WRITE;
      default:  return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/phase_prescaler.sv
// Phase timer: counts up from 0 after each load and stops at the limit.
//   clk, nrst : system clock, synchronous active-low reset
//   load      : restart the count at 0 (asserted on every phase entry)
//   limit     : last count value of the phase (phase length - 1)
//   tc        : terminal count, high on the last cycle of the phase
module phase_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [DIV_W-1:0] limit,
  output logic             tc
);

  logic [DIV_W-1:0] count;

  assign tc = (count == limit);

  // Holds at the terminal value instead of wrapping; the FSM always
  // leaves the phase on tc, so the hold only matters in untimed states.
  always_ff @(posedge clk) begin
    if (!nrst)     count <= '0;
    else if (load) count <= '0;
    else if (!tc)  count <= count + DIV_W'(1);
  end

endmodule

// File: rtl/bf_exec_sequencer.sv
// Instruction-execution sequencer: paces the core through read/decode/write
// phases of N = max(div_ratio,1) cycles each and arbitrates a shared RAM port
// between the core and a debug requester at instruction boundaries.
//   clk, nrst                    : system clock, synchronous active-low reset
//   div_ratio                    : cycles per phase, latched on READ entry
//   run, step_req                : free-run level / single-step pulse
//   core_finish                  : program overrun, parks the sequencer in FIN
//   rd_en, dec_en, wr_en         : one-cycle phase strobes to the core
//   core_addr, core_wdata        : core side of the RAM port
//   dbg_req/we/addr/wdata        : debug access request
//   dbg_gnt, dbg_rvalid, dbg_rdata : debug grant and read return
//   ram_ce/we/ad/din, ram_dout   : shared RAM port (1-cycle read latency)
//   halted, done                 : at instruction boundary / program finished
//
// state  | meaning
// HALT   | idle at an instruction boundary, waiting for run/step/debug
// READ   | N-cycle phase, rd_en and core RAM read on the last cycle
// DECODE | N-cycle phase, dec_en on the last cycle
// WRITE  | N-cycle phase, wr_en and core RAM write on the last cycle
// DBG    | single cycle owning the RAM port for the debug access
// FIN    | program finished; only debug accesses are served
module bf_exec_sequencer
  import bf_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DIV_W-1:0]  div_ratio,
  input  logic              run,
  input  logic              step_req,
  input  logic              core_finish,
  output logic              rd_en,
  output logic              dec_en,
  output logic              wr_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              halted,
  output logic              done
);

  state_t           state, state_next, boundary_next;
  logic [DIV_W-1:0] n_q;
  logic             step_pend, ret_fin, rvalid_q, tc, load, enter_read;
  logic [DATA_W-1:0] rdata_q;

  assign load       = (phase_of(state_next) != phase_of(state));
  assign enter_read = (state_next == S_READ) && (state != S_READ);

  phase_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk   (clk),
    .nrst  (nrst),
    .load  (load),
    .limit (n_q - DIV_W'(1)),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_HALT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    dec_en     = 1'b0;
    wr_en      = 1'b0;
    dbg_gnt    = 1'b0;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_ad     = core_addr;
    ram_din    = core_wdata;

    if (dbg_req)                boundary_next = S_DBG;
    else if (core_finish)       boundary_next = S_FIN;
    else if (run || step_pend)  boundary_next = S_READ;
    else                        boundary_next = S_HALT;

    case (state)
      S_HALT:   state_next = boundary_next;
      S_READ: if (tc) begin
        rd_en      = 1'b1;
        ram_ce     = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: if (tc) begin
        dec_en     = 1'b1;
        state_next = S_WRITE;
      end
      S_WRITE: if (tc) begin
        wr_en      = 1'b1;
        ram_ce     = 1'b1;
        ram_we     = 1'b1;
        state_next = boundary_next;
      end
      S_DBG: begin
        dbg_gnt = 1'b1;
        ram_ce  = 1'b1;
        ram_we  = dbg_we;
        ram_ad  = dbg_addr;
        ram_din = dbg_wdata;
        // A still-asserted dbg_req is not re-arbitrated here: the request
        // was consumed by this grant.
        if (ret_fin || core_finish) state_next = S_FIN;
        else if (run || step_pend)  state_next = S_READ;
        else                        state_next = S_HALT;
      end
      S_FIN: if (dbg_req) state_next = S_DBG;
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      n_q       <= DIV_W'(1);
      step_pend <= 1'b0;
      ret_fin   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (enter_read) n_q <= (div_ratio == '0) ? DIV_W'(1) : div_ratio;
      if (enter_read)
        step_pend <= 1'b0;
      else if (state == S_HALT && step_req && !run)
        step_pend <= 1'b1;
      if (state_next == S_DBG && state != S_DBG) ret_fin <= (state == S_FIN);
      rvalid_q <= (state == S_DBG) && !dbg_we;
      if (rvalid_q) rdata_q <= ram_dout;
    end
  end

  // RAM data arrives one cycle after the grant; pass it straight through on
  // that cycle and keep the captured copy afterwards.
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rvalid_q ? ram_dout : rdata_q;
  assign halted     = (state == S_HALT) || (state == S_FIN);
  assign done       = (state == S_FIN);

endmodule

// File: tb/tb_bf_exec_sequencer.sv
module tb_bf_exec_sequencer;
  localparam int M_IDLE = 0, M_EXEC = 1, M_DBG = 2, M_FIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst, run, step_req, core_finish, dbg_req, dbg_we;
  logic [7:0] div_ratio, dbg_addr, dbg_wdata;
  logic [7:0] core_addr = 8'h80;
  logic [7:0] core_wdata = 8'h11;
  logic       rd_en, dec_en, wr_en, dbg_gnt, dbg_rvalid, ram_ce, ram_we, halted, done;
  logic [7:0] dbg_rdata, ram_ad, ram_din, ram_dout;

  bf_exec_sequencer #(.DIV_W(8), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .nrst(nrst), .div_ratio(div_ratio), .run(run), .step_req(step_req),
    .core_finish(core_finish), .rd_en(rd_en), .dec_en(dec_en), .wr_en(wr_en),
    .core_addr(core_addr), .core_wdata(core_wdata), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .ram_ce(ram_ce), .ram_we(ram_we), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .halted(halted), .done(done)
  );

  int   cyc = 0;
  int   n_cmp = 0, n_mis = 0;
  int   rd_cnt = 0, dec_cnt = 0, wr_cnt = 0;
  logic init_done = 1'b0;
  logic [7:0] ram_mem [256];
  logic [7:0] mem_m [256];

  // RAM attached to the shared port
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'hA5;
      ram_mem[16] <= 8'h5A;
      init_done   <= 1'b1;
    end else if (ram_ce) begin
      if (ram_we) ram_mem[ram_ad] <= ram_din;
      else        ram_dout <= ram_mem[ram_ad];
    end
  end

  // core data pointer / write value keep moving; MSB set keeps the core away
  // from the debug test locations
  initial forever begin
    @(posedge clk); #1;
    core_addr  = {1'b1, core_addr[6:0] + 7'd5};
    core_wdata = core_wdata + 8'd29;
  end

  // ---------------- behavioural model ----------------
  // An instruction is one block of 3N cycles numbered k = 0..3N-1;
  // strobes fall on k = N-1, 2N-1, 3N-1.
  int         m_mode = M_IDLE, m_k = 0, m_n = 1;
  bit         m_pend = 1'b0, m_retfin = 1'b0, m_rvalid = 1'b0;
  logic [7:0] m_rexp = 8'h00, m_last = 8'h00;

  function automatic int bnd_mode();
    if (dbg_req)        return M_DBG;
    if (core_finish)    return M_FIN;
    if (run || m_pend)  return M_EXEC;
    return M_IDLE;
  endfunction

  function automatic int next_mode();
    case (m_mode)
      M_IDLE:  return bnd_mode();
      M_EXEC:  return (m_k == 3*m_n-1) ? bnd_mode() : M_EXEC;
      M_DBG:   return (m_retfin || core_finish) ? M_FIN : ((run || m_pend) ? M_EXEC : M_IDLE);
      default: return dbg_req ? M_DBG : M_FIN;
    endcase
  endfunction

  function automatic bit starting();
    return (next_mode() == M_EXEC) && (m_mode != M_EXEC || m_k == 3*m_n-1);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= 8'(i) ^ 8'hA5;
      mem_m[16] <= 8'h5A;
    end
    if (!nrst) begin
      m_mode <= M_IDLE; m_k <= 0; m_n <= 1; m_pend <= 1'b0;
      m_retfin <= 1'b0; m_rvalid <= 1'b0; m_last <= 8'h00;
    end else begin
      m_mode <= next_mode();
      if (starting()) begin
        m_k <= 0;
        m_n <= (div_ratio == 8'd0) ? 1 : int'(div_ratio);
      end else if (m_mode == M_EXEC) m_k <= m_k + 1;
      if (starting()) m_pend <= 1'b0;
      else if (m_mode == M_IDLE && step_req && !run) m_pend <= 1'b1;
      if (next_mode() == M_DBG && m_mode != M_DBG) m_retfin <= (m_mode == M_FIN);
      m_rvalid <= (m_mode == M_DBG) && !dbg_we;
      if (m_mode == M_DBG && !dbg_we) m_rexp <= mem_m[dbg_addr];
      if (m_rvalid) m_last <= m_rexp;
      if (m_mode == M_DBG && dbg_we) mem_m[dbg_addr] <= dbg_wdata;
      if (m_mode == M_EXEC && m_k == 3*m_n-1) mem_m[core_addr] <= core_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic e_rd, e_dec, e_wr, e_gnt, e_ce, e_we;
  initial forever begin
    @(negedge clk);
    e_rd  = (m_mode == M_EXEC) && (m_k == m_n-1);
    e_dec = (m_mode == M_EXEC) && (m_k == 2*m_n-1);
    e_wr  = (m_mode == M_EXEC) && (m_k == 3*m_n-1);
    e_gnt = (m_mode == M_DBG);
    e_ce  = e_rd | e_wr | e_gnt;
    e_we  = e_wr | (e_gnt & dbg_we);
    chk("strobes", {29'd0, rd_en, dec_en, wr_en}, {29'd0, e_rd, e_dec, e_wr});
    chk("status", {28'd0, halted, done, dbg_gnt, dbg_rvalid},
        {28'd0, (m_mode == M_IDLE || m_mode == M_FIN), (m_mode == M_FIN), e_gnt, m_rvalid});
    chk("ram_ctl", {30'd0, ram_ce, ram_we}, {30'd0, e_ce, e_we});
    if (e_ce) chk("ram_ad", {24'd0, ram_ad}, {24'd0, e_gnt ? dbg_addr : core_addr});
    if (e_we) chk("ram_din", {24'd0, ram_din}, {24'd0, e_gnt ? dbg_wdata : core_wdata});
    chk("dbg_rdata", {24'd0, dbg_rdata}, {24'd0, m_rvalid ? m_rexp : m_last});
    if (rd_en)  rd_cnt++;
    if (dec_en) dec_cnt++;
    if (wr_en)  wr_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int sel, input int budget, input string nm, output int t);
    bit hit;
    logic v;
    hit = 1'b0;
    t   = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: v = rd_en;
        1: v = dec_en;
        2: v = wr_en;
        3: v = dbg_gnt;
        default: v = dbg_rvalid;
      endcase
      if (v) begin hit = 1'b1; t = cyc; end
    end
    if (!hit) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, t2, t3, t4, b_rd, b_dec, b_wr;
    nrst = 1'b0; run = 1'b0; step_req = 1'b0; core_finish = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    div_ratio = 8'd4;
    tick(3);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);

    // free run, N=4
    nrst = 1'b1; run = 1'b1;
    wait_sig(0, 40, "t1_rd", t0);
    wait_sig(1, 40, "t1_dec", t1);
    wait_sig(2, 40, "t1_wr", t2);
    wait_sig(0, 40, "t1_rd2", t3);
    chk("t1_rd_to_dec", t1 - t0, 32'd4);
    chk("t1_dec_to_wr", t2 - t1, 32'd4);
    chk("t1_wr_to_rd", t3 - t2, 32'd4);
    tick(1); run = 1'b0;
    wait_sig(2, 40, "t1_wr2", t2);
    tick(3);
    chk("t1_halted", {31'd0, halted}, 32'd1);

    // single step, second pulse during execution ignored
    b_rd = rd_cnt; b_dec = dec_cnt; b_wr = wr_cnt;
    step_req = 1'b1; tick(1); step_req = 1'b0;
    tick(6);
    step_req = 1'b1; tick(1); step_req = 1'b0;
    tick(30);
    chk("t2_rd_cnt", rd_cnt - b_rd, 32'd1);
    chk("t2_dec_cnt", dec_cnt - b_dec, 32'd1);
    chk("t2_wr_cnt", wr_cnt - b_wr, 32'd1);
    chk("t2_halted", {31'd0, halted}, 32'd1);

    // debug read requested mid-DECODE
    run = 1'b1;
    wait_sig(0, 40, "t3_rd", t0);
    tick(2);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    wait_sig(2, 40, "t3_wr", t1);
    wait_sig(3, 40, "t3_gnt", t2);
    tick(1); dbg_req = 1'b0;
    wait_sig(4, 5, "t3_rvalid", t3);
    chk("t3_gnt_latency", t2 - t1, 32'd1);
    chk("t3_rvalid_latency", t3 - t2, 32'd1);
    chk("t3_rdata", {24'd0, dbg_rdata}, 32'h5A);
    wait_sig(0, 20, "t3_resume_rd", t0);
    tick(1); run = 1'b0;
    wait_sig(2, 40, "t3_wr2", t1);
    tick(3);

    // core_finish during WRITE, then debug write/read in FIN
    run = 1'b1;
    wait_sig(1, 40, "t4_dec", t0);
    tick(1); core_finish = 1'b1;
    wait_sig(2, 40, "t4_wr", t1);
    tick(2);
    chk("t4_done", {31'd0, done}, 32'd1);
    b_rd = rd_cnt;
    tick(20);
    chk("t4_no_rd", rd_cnt - b_rd, 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h02; dbg_wdata = 8'h33;
    wait_sig(3, 10, "t4_wgnt", t2);
    tick(1); dbg_req = 1'b0;
    tick(2);
    chk("t4_done_after_dbg", {31'd0, done}, 32'd1);
    dbg_req = 1'b1; dbg_we = 1'b0;
    wait_sig(3, 10, "t4_rgnt", t2);
    tick(1); dbg_req = 1'b0;
    wait_sig(4, 5, "t4_rvalid", t3);
    chk("t4_rdata", {24'd0, dbg_rdata}, 32'h33);

    // reset during DECODE aborts without a write strobe
    nrst = 1'b0; tick(2);
    core_finish = 1'b0; nrst = 1'b1; run = 1'b1;
    wait_sig(0, 40, "t5_rd", t0);
    tick(1); nrst = 1'b0;
    b_wr = wr_cnt;
    tick(2); run = 1'b0; nrst = 1'b1;
    tick(20);
    chk("t5_no_wr", wr_cnt - b_wr, 32'd0);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_rdata_cleared", {24'd0, dbg_rdata}, 32'd0);

    // div_ratio held per instruction; 0 behaves as 1
    div_ratio = 8'd3; run = 1'b1;
    wait_sig(0, 40, "t6_rd", t0);
    tick(1); div_ratio = 8'd0;
    wait_sig(1, 40, "t6_dec", t1);
    wait_sig(2, 40, "t6_wr", t2);
    wait_sig(0, 40, "t6_rd2", t3);
    wait_sig(1, 40, "t6_dec2", t4);
    chk("t6_rd_to_dec", t1 - t0, 32'd3);
    chk("t6_dec_to_wr", t2 - t1, 32'd3);
    chk("t6_wr_to_rd_n1", t3 - t2, 32'd1);
    chk("t6_rd_to_dec_n1", t4 - t3, 32'd1);
    tick(1); run = 1'b0;
    tick(5);
    chk("t6_halted", {31'd0, halted}, 32'd1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bf_exec_sequencer.md
BF_EXEC_SEQUENCER -- requirements
Module: bf_exec_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 8: prescaler width.
REQ-002 SHALL have parameter ADDR_W, default 8: data-RAM address width.
REQ-003 SHALL have parameter DATA_W, default 8: data-RAM word width.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port div_ratio, input, DIV_W: clk cycles per phase; 0 treated as 1.
REQ-007 SHALL have port run, input, 1: level; free-run execution while high.
REQ-008 SHALL have port step_req, input, 1: pulse; execute exactly one instruction while halted.
REQ-009 SHALL have port core_finish, input, 1: program ROM overrun from core.
REQ-010 SHALL have port rd_en, output, 1: RAM-read phase strobe.
REQ-011 SHALL have port dec_en, output, 1: core decode/execute strobe.
REQ-012 SHALL have port wr_en, output, 1: RAM-write and pointer-update strobe.
REQ-013 SHALL have port core_addr, input, ADDR_W: core data pointer.
REQ-014 SHALL have port core_wdata, input, DATA_W: core write value.
REQ-015 SHALL have port dbg_req, dbg_we, dbg_addr, dbg_wdata, inputs, 1/1/ADDR_W/DATA_W: debug RAM access request.
REQ-016 SHALL have port dbg_gnt, output, 1: one-cycle grant; request consumed.
REQ-017 SHALL have port dbg_rvalid, dbg_rdata, outputs, 1/DATA_W: read data qualifier and data.
REQ-018 SHALL have port ram_ce, ram_we, ram_ad, ram_din, outputs, 1/1/ADDR_W/DATA_W: shared RAM port.
REQ-019 SHALL have port ram_dout, input, DATA_W: RAM read data, 1-cycle latency after ram_ce.
REQ-020 SHALL have port halted, done, outputs, 1/1: halted at instruction boundary / program finished.

Function
REQ-021 SHALL implement states HALT, READ, DECODE, WRITE, DBG, FIN.
REQ-022 Phase length SHALL be N = max(div_ratio,1) clk cycles, with div_ratio sampled on entry to READ and held for the whole instruction.
REQ-023 rd_en, dec_en, and wr_en SHALL each pulse high for exactly one clk on the last cycle of READ, DECODE, and WRITE respectively; never two at once.
REQ-024 Transitions: READ->DECODE->WRITE, each on its strobe cycle.
REQ-025 Priority from HALT and at the end of WRITE: dbg_req -> DBG; else core_finish -> FIN; else run or pending step -> READ; else HALT.
REQ-026 step_req SHALL be latched as pending only in HALT, cleared on entry to READ, and ignored while run=1 or in FIN.
REQ-027 DBG SHALL last one cycle: ram_ce=1, ram_we=dbg_we, ram_ad=dbg_addr, ram_din=dbg_wdata, dbg_gnt=1; it then returns to the state it came from (HALT, or READ when run=1, or FIN).
REQ-028 For a debug read, dbg_rvalid SHALL be 1 for exactly the cycle after dbg_gnt, with dbg_rdata=ram_dout; otherwise dbg_rdata holds its last value.
REQ-029 The core RAM port SHALL be driven as follows: rd_en cycle gives ram_ce=1, ram_we=0, ram_ad=core_addr; wr_en cycle gives ram_ce=1, ram_we=1, ram_ad=core_addr, ram_din=core_wdata; all other cycles give ram_ce=0, ram_we=0.
REQ-030 Debug SHALL never preempt an instruction in progress; worst-case grant latency is 3N+1 cycles.
REQ-031 FIN SHALL be absorbing except for DBG; done=1 in FIN. halted=1 in HALT and FIN.
REQ-032 The prescaler SHALL reset to 0 on each phase entry and never wrap mid-phase.

Reset
REQ-033 While nrst=0 at a clk edge: state=HALT, prescaler=0, step pending=0, all strobes/ram_ce/ram_we/dbg_gnt/dbg_rvalid=0, dbg_rdata=0, halted=1, done=0.
REQ-034 Reset mid-instruction SHALL abort without a wr_en pulse.

Structure
REQ-035 The state enum and phase identifiers SHALL live in shared package bf_pkg.
REQ-036 The prescaler SHALL be sub-module phase_prescaler (load, count, terminal-count out).

Verification
REQ-037 div_ratio=4, run=1: rd_en/dec_en/wr_en pulses spaced 4 cycles, wr_en to next rd_en = 4 cycles.
REQ-038 run=0, step_req pulse: exactly one rd_en, dec_en, wr_en, then halted=1; second step_req during execution is ignored.
REQ-039 dbg_req mid-DECODE, run=1: dbg_gnt 1 cycle after wr_en; read of addr 0x10 containing 0x5A gives dbg_rvalid next cycle with 0x5A; execution resumes.
REQ-040 core_finish=1 during WRITE: FIN, done=1, no further rd_en; dbg write 0x33 to 0x02 is still granted.
REQ-041 nrst low during DECODE: no wr_en; after release, state HALT, halted=1.
REQ-042 div_ratio=0: behaves as N=1, strobes on consecutive cycles.
